// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-cathode 7-segment display.
// Incoming data is double-buffered and only swapped into the displayed frame at a frame boundary.
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dots_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic [3:0]          num,
  output logic                dot,
  output logic [DIGITS-1:0]   cat,
  output logic                frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_act_data;
  logic [DIGITS-1:0]   r_act_dots;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dots;
  logic                r_pend_valid;
  logic [3:0]          r_num;
  logic                r_dot;
  logic [DIGITS-1:0]   r_cat;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_wrap;
  logic [DIGITS-1:0]   w_zero_from;
  logic [3:0]          w_cur_nib;
  logic                w_cur_dot;
  logic                w_cur_blank;
  logic [DIGITS-1:0]   w_cur_cat;

  assign w_tick = (r_presc == PRESC_TC);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // w_zero_from[k]: nibbles DIGITS-1 down to k of the active value are all zero
  always_comb begin
    logic v_zero;
    v_zero      = 1'b1;
    w_zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_zero         = v_zero && (r_act_data[4*k +: 4] == 4'h0);
      w_zero_from[k] = v_zero;
    end
  end

  always_comb begin
    w_cur_nib   = 4'h0;
    w_cur_dot   = 1'b0;
    w_cur_blank = 1'b0;
    w_cur_cat   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_cur_nib    = r_act_data[4*k +: 4];
        w_cur_dot    = r_act_dots[k];
        w_cur_blank  = (k != 0) && w_zero_from[k];
        w_cur_cat[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
    end
  end

  // A load coinciding with the boundary goes straight to active, bypassing pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data   <= '0;
      r_act_dots   <= '0;
      r_pend_data  <= '0;
      r_pend_dots  <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_wrap) begin
      r_pend_valid <= 1'b0;
      if (load) begin
        r_act_data <= data_in;
        r_act_dots <= dots_in;
      end else if (r_pend_valid) begin
        r_act_data <= r_pend_data;
        r_act_dots <= r_pend_dots;
      end
    end else if (load) begin
      r_pend_data  <= data_in;
      r_pend_dots  <= dots_in;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num        <= 4'hF;
      r_dot        <= 1'b0;
      r_cat        <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_num        <= (blank_lz && w_cur_blank) ? 4'hF : w_cur_nib;
      r_dot        <= w_cur_dot;
      r_cat        <= w_cur_cat;
      r_frame_done <= w_wrap;
    end
  end

  assign num        = r_num;
  assign dot        = r_dot;
  assign cat        = r_cat;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, checked against a
// cycle-count arithmetic model of the scan, buffering and blanking rules.
module tb_seg_scan_ctrl;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dots_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  num;
  logic        dot;
  logic [7:0]  cat;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // model: edges since reset release, displayed and pending frames
  int          m_n = 0;
  logic [31:0] m_act_d = '0;
  logic [7:0]  m_act_t = '0;
  logic [31:0] m_pend_d = '0;
  logic [7:0]  m_pend_t = '0;
  logic        m_pend_v = 1'b0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dots_in(dots_in),
    .load(load), .blank_lz(blank_lz), .num(num), .dot(dot), .cat(cat),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_num(input int k, input logic [31:0] d, input logic blz);
    int hi;
    hi = -1;
    for (int j = 0; j < DIGITS; j++) if (d[j*4 +: 4] != 4'h0) hi = j;
    if (blz && k != 0 && k > hi) return 4'hF;
    return d[k*4 +: 4];
  endfunction

  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] dt, input logic blz);
    int         idx;
    logic       bnd;
    logic [3:0] en;
    logic       ed;
    logic [7:0] ec;
    load = ld; data_in = d; dots_in = dt; blank_lz = blz;
    idx = (m_n / SCAN_DIV) % DIGITS;
    bnd = (m_n % FRAME) == FRAME - 1;
    en  = exp_num(idx, m_act_d, blz);
    ed  = m_act_t[idx];
    ec  = ~(8'd1 << idx);
    @(posedge clk); #1;
    if (bnd) begin
      if (ld) begin
        m_act_d = d; m_act_t = dt;
      end else if (m_pend_v) begin
        m_act_d = m_pend_d; m_act_t = m_pend_t;
      end
      m_pend_v = 1'b0;
    end else if (ld) begin
      m_pend_d = d; m_pend_t = dt; m_pend_v = 1'b1;
    end
    m_n++;
    check("cat", 32'(cat), 32'(ec));
    check("num", 32'(num), 32'(en));
    check("dot", 32'(dot), 32'(ed));
    check("frame_done", 32'(frame_done), 32'(bnd));
    load = 1'b0;
  endtask

  task automatic run_to(input int phase, input logic blz);
    while ((m_n % FRAME) != phase) step(1'b0, $urandom, 8'($urandom), blz);
  endtask

  task automatic idle(input int cycles, input logic blz);
    for (int i = 0; i < cycles; i++) step(1'b0, $urandom, 8'($urandom), blz);
  endtask

  initial begin
    logic blz;
    logic [31:0] rd;
    #23;
    check("rst_cat", 32'(cat), 32'hFF);
    check("rst_num", 32'(num), 32'hF);
    check("rst_dot", 32'(dot), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // free-running scan across two frames
    idle(70, 1'b0);

    // mid-frame load, then hold until it is fully shown
    run_to(6, 1'b0);
    step(1'b1, 32'h12345678, 8'h01, 1'b0);
    idle(FRAME + 8, 1'b0);

    // last load in a frame wins
    run_to(5, 1'b0);
    step(1'b1, 32'h11111111, 8'h00, 1'b0);
    run_to(20, 1'b0);
    step(1'b1, 32'h22222222, 8'h00, 1'b0);
    idle(FRAME + 8, 1'b0);

    // load on the boundary tick is displayed with no extra frame of delay
    run_to(FRAME - 1, 1'b0);
    step(1'b1, 32'h00000009, 8'h00, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b0);
    check("tp4_digit0", 32'(num), 32'h9);
    idle(FRAME, 1'b0);

    // leading-zero blanking
    run_to(10, 1'b1);
    step(1'b1, 32'h00000905, 8'h20, 1'b1);
    idle(FRAME + 30, 1'b1);
    step(1'b1, 32'h00000000, 8'h00, 1'b1);
    idle(FRAME + 30, 1'b1);

    // async reset at idx 5 with pending data
    run_to(10, 1'b0);
    step(1'b1, 32'hAAAAAAAA, 8'hFF, 1'b0);
    run_to(21, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cat", 32'(cat), 32'hFF);
    check("arst_num", 32'(num), 32'hF);
    check("arst_dot", 32'(dot), 32'h0);
    check("arst_fd", 32'(frame_done), 32'h0);
    m_n = 0; m_act_d = '0; m_act_t = '0; m_pend_v = 1'b0;
    #20 rst_n = 1'b1;
    idle(2 * FRAME + 4, 1'b0);

    // randomized loads and blanking
    blz = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      rd = $urandom >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 15) == 0, rd, 8'($urandom), blz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
